// File: rtl/control_pkg.sv
// Shared definitions for the ID-stage control decoder: opcodes, ALU op codes
// and the packed control word that crosses the ID/EX boundary.
package control_pkg;

    localparam int OPCODE_W = 6;
    localparam int ALU_OP_W = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    localparam logic [ALU_OP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic                reg_dst;
        logic                alu_src;
        logic                mem_to_reg;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic                jump;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/control_decode.sv
// Purely combinational opcode decoder: maps the instruction opcode to a
// control word and flags opcodes the pipeline does not implement.
module control_decode
    import control_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_word_t          ctrl,
    output logic                illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_SUB;
            end
            OP_ADDI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// ID-stage main control: decodes the opcode and registers the control word
// into the ID/EX boundary with stall (hold) and flush (bubble) support.
module control_unit
    import control_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                stall,
    input  logic                flush,
    output logic                reg_dst,
    output logic                jump,
    output logic                branch,
    output logic                mem_read,
    output logic                mem_to_reg,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                mem_write,
    output logic                alu_src,
    output logic                reg_write,
    output logic                illegal
);

    ctrl_word_t dec_ctrl;
    logic       dec_illegal;
    ctrl_word_t ctrl_q;
    logic       illegal_q;

    control_decode u_decode (
        .opcode  (opcode),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    // Flush wins over stall so a bubble can be injected into a held stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all state so every register
            // samples pre-edge values regardless of statement order.
            ctrl_q    <= CTRL_NOP;
            illegal_q <= 1'b0;
        end else if (flush) begin
            ctrl_q    <= CTRL_NOP;
            illegal_q <= 1'b0;
        end else if (!stall) begin
            ctrl_q    <= dec_ctrl;
            illegal_q <= dec_illegal;
        end
    end

    assign reg_dst    = ctrl_q.reg_dst;
    assign alu_src    = ctrl_q.alu_src;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign reg_write  = ctrl_q.reg_write;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign branch     = ctrl_q.branch;
    assign jump       = ctrl_q.jump;
    assign alu_op     = ctrl_q.alu_op;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: table vectors, hand-written reset
// and flush/stall sequences, then a random stream against a lookup model.
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       stall;
    logic       flush;
    logic       reg_dst, jump, branch, mem_read, mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write, alu_src, reg_write, illegal;

    int total = 0;
    int bad   = 0;

    // {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
    //  branch, jump, alu_op[1:0], illegal}
    logic [10:0] model_q;

    localparam logic [10:0] W_R    = 11'b10010000100;
    localparam logic [10:0] W_LW   = 11'b01111000000;
    localparam logic [10:0] W_SW   = 11'b01000100000;
    localparam logic [10:0] W_BEQ  = 11'b00000010010;
    localparam logic [10:0] W_ADDI = 11'b01010000000;
    localparam logic [10:0] W_J    = 11'b00000001000;
    localparam logic [10:0] W_ILL  = 11'b00000000001;
    localparam logic [10:0] W_NOP  = 11'b00000000000;

    logic [5:0]  legal_ops   [6];
    logic [10:0] legal_words [6];

    typedef struct {
        logic [5:0]  op;
        logic        stall;
        logic        flush;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs [16];

    control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .stall      (stall),
        .flush      (flush),
        .reg_dst    (reg_dst),
        .jump       (jump),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_to_reg (mem_to_reg),
        .alu_op     (alu_op),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] dut_word();
        return {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
                branch, jump, alu_op, illegal};
    endfunction

    function automatic logic [10:0] ref_decode(input logic [5:0] op);
        for (int i = 0; i < 6; i++)
            if (legal_ops[i] == op) return legal_words[i];
        return W_ILL;
    endfunction

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b (op=%b stall=%b flush=%b)",
                     name, got, exp, opcode, stall, flush);
        end
    endtask

    // One clock edge with the model tracking the register's priority rules.
    task automatic step();
        logic [10:0] nxt;
        nxt = model_q;
        if (flush)       nxt = W_NOP;
        else if (!stall) nxt = ref_decode(opcode);
        @(posedge clk);
        model_q = rst_n ? nxt : W_NOP;
        #1;
    endtask

    initial begin
        legal_ops[0] = 6'b000000; legal_words[0] = W_R;
        legal_ops[1] = 6'b100011; legal_words[1] = W_LW;
        legal_ops[2] = 6'b101011; legal_words[2] = W_SW;
        legal_ops[3] = 6'b000100; legal_words[3] = W_BEQ;
        legal_ops[4] = 6'b001000; legal_words[4] = W_ADDI;
        legal_ops[5] = 6'b000010; legal_words[5] = W_J;

        vecs[0]  = '{6'b000000, 1'b0, 1'b0, W_R};
        vecs[1]  = '{6'b100011, 1'b0, 1'b0, W_LW};
        vecs[2]  = '{6'b101011, 1'b0, 1'b0, W_SW};
        vecs[3]  = '{6'b000100, 1'b0, 1'b0, W_BEQ};
        vecs[4]  = '{6'b001000, 1'b0, 1'b0, W_ADDI};
        vecs[5]  = '{6'b000010, 1'b0, 1'b0, W_J};
        vecs[6]  = '{6'b111111, 1'b0, 1'b0, W_ILL};
        vecs[7]  = '{6'b100011, 1'b0, 1'b0, W_LW};
        vecs[8]  = '{6'b101011, 1'b0, 1'b0, W_SW};
        vecs[9]  = '{6'b000100, 1'b1, 1'b0, W_SW};
        vecs[10] = '{6'b000100, 1'b1, 1'b0, W_SW};
        vecs[11] = '{6'b000100, 1'b1, 1'b0, W_SW};
        vecs[12] = '{6'b000100, 1'b0, 1'b0, W_BEQ};
        vecs[13] = '{6'b000010, 1'b1, 1'b1, W_NOP};
        vecs[14] = '{6'b000010, 1'b0, 1'b0, W_J};
        vecs[15] = '{6'b010101, 1'b0, 1'b1, W_NOP};

        rst_n   = 1'b0;
        opcode  = 6'b000000;
        stall   = 1'b0;
        flush   = 1'b0;
        model_q = W_NOP;

        #12;
        check("reset_hold", dut_word(), W_NOP);
        rst_n = 1'b1;
        step();
        check("post_reset_rtype", dut_word(), W_R);

        // Asynchronous reset asserted mid-cycle must clear outputs before any edge.
        opcode = 6'b100011;
        step();
        check("lw_before_async", dut_word(), W_LW);
        opcode = 6'b000000;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", dut_word(), W_NOP);
        model_q = W_NOP;
        step();
        check("reset_held_across_edge", dut_word(), W_NOP);
        #2;
        rst_n = 1'b1;
        step();
        check("first_capture_after_reset", dut_word(), W_R);

        for (int i = 0; i < 16; i++) begin
            opcode = vecs[i].op;
            stall  = vecs[i].stall;
            flush  = vecs[i].flush;
            step();
            check($sformatf("vec%0d", i), dut_word(), vecs[i].exp);
        end
        stall = 1'b0;
        flush = 1'b0;

        // Random stream against the model, with invariant checks every cycle.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(1, 0) == 1) opcode = legal_ops[$urandom_range(5, 0)];
            else                           opcode = 6'($urandom);
            stall = ($urandom_range(3, 0) == 0);
            flush = ($urandom_range(7, 0) == 0);
            step();
            check("rand_word", dut_word(), model_q);
            check("inv_mem_rw", {10'b0, mem_read & mem_write}, 11'b0);
            check("inv_br_j", {10'b0, branch & jump}, 11'b0);
            check("inv_regwrite", {10'b0, reg_write & (mem_write | branch | jump)}, 11'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main control decoder for the 5-stage MIPS pipeline, sitting in the ID stage.
- Decodes the 6-bit instruction opcode into datapath control signals (register destination, ALU source/op, memory read/write, write-back select, branch, jump).
- Outputs are registered into the ID/EX boundary, with stall (hold) and flush (bubble) support.
- Unsupported opcodes produce a NOP control word and raise an illegal-instruction flag.

Parameters:
- ALU_OP_W, 2, width of alu_op field.
- OPCODE_W, 6, width of opcode field.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instruction bits [31:26]
- stall  input  1  hold current registered control word
- flush  input  1  load NOP control word (bubble)
- reg_dst  output  1  1 = write rd, 0 = write rt
- jump  output  1  unconditional jump
- branch  output  1  beq branch candidate
- mem_read  output  1  data memory read
- mem_to_reg  output  1  1 = write-back from memory, 0 = from ALU
- alu_op  output  2  00 add, 01 subtract (compare), 10 R-type funct decode, 11 reserved/unused
- mem_write  output  1  data memory write
- alu_src  output  1  1 = immediate operand, 0 = rt
- reg_write  output  1  register file write enable
- illegal  output  1  opcode not supported

Behaviour:
- Combinational decode. The tuple is reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, alu_op.
  - 000000 R-type: 1,0,0,1,0,0,0,0,10
  - 100011 lw: 0,1,1,1,1,0,0,0,00
  - 101011 sw: 0,1,0,0,0,1,0,0,00
  - 000100 beq: 0,0,0,0,0,0,1,0,01
  - 001000 addi: 0,1,0,1,0,0,0,0,00
  - 000010 j: 0,0,0,0,0,0,0,1,00
  - Any other opcode: all zero (NOP word), illegal=1. illegal=0 for the six opcodes above.
- Don't-care fields are driven to 0:
  - sw: reg_dst, mem_to_reg.
  - beq: reg_dst, alu_src, mem_to_reg.
  - j: all fields except jump.
- Registered outputs: all outputs update on the rising clk edge; latency is 1 cycle from opcode to output.
- Reset: rst_n low asynchronously forces every output to 0 (NOP word, illegal=0), independent of clk. Outputs are held at 0 while rst_n is low. The first capture occurs on the first rising edge after rst_n deasserts.
- Priority at the clock edge: flush > stall > normal load.
  - flush=1: load NOP word, illegal=0.
  - stall=1 and flush=0: retain the previous value.
  - Otherwise: load the decoded word.
- Invariants:
  - mem_read and mem_write are never both 1.
  - At most one of branch and jump is 1.
  - reg_write=0 whenever mem_write, branch or jump is 1.
- X on opcode is not required to be handled; the bench drives only known values.

Decomposition:
- Shared package control_pkg holds:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - ALU_OP constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
  - A packed control-word typedef ctrl_word_t and a CTRL_NOP constant.
- One natural sub-module, control_decode: the purely combinational opcode-to-ctrl_word_t and illegal decoder. control_unit wraps it with the stall/flush pipeline register.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with opcode=000000 -> all outputs 0 immediately, without waiting for clk; release rst_n, next edge -> R-type word.
- Sweep opcodes 000000, 100011, 101011, 000100, 001000, 000010, one per cycle -> outputs one cycle later match the table exactly, e.g. lw gives alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00.
- Illegal: opcode=111111 -> next edge all control 0, illegal=1; then opcode=100011 -> illegal=0.
- Stall: load sw, then stall=1 while opcode=000100 for 3 cycles -> mem_write stays 1 and branch stays 0; release stall -> branch=1, alu_op=01.
- Flush over stall: opcode=000010, stall=1 and flush=1 together -> all outputs 0 next edge; flush=0, stall=0 -> jump=1.
- Invariant check every cycle during a random legal/illegal opcode stream: never mem_read&mem_write, never branch&jump.
